// File: rtl/cache_arb_pkg.sv
// Shared types and constants for the two-port cache arbiter: FSM encoding,
// cache state values the arbiter decodes, and nominal transaction latencies.
package cache_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_BUSY  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_t;

  localparam logic [3:0] C_IDLE     = 4'd0;
  localparam logic [3:0] C_MISS_MIN = 4'd2;

  // Accept edge to ack edge, in clock cycles.
  localparam int LAT_HIT   = 3;
  localparam int LAT_RMISS = 15;
  localparam int LAT_WMISS = 13;

endpackage

// File: rtl/cache_arb_rr.sv
// Two-way request picker: round-robin on a last-grant pointer, or fixed
// priority to port 0 when FIXED_PRIO is nonzero.
module cache_arb_rr #(
  parameter int FIXED_PRIO = 0
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] pick
);

  // Reset value 1 means "port 1 went last", so port 0 wins the first tie.
  logic last_p1;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      last_p1 <= 1'b1;
    end else if (advance) begin
      last_p1 <= pick[1];
    end
  end

  always_comb begin
    // NOTE: assign a default before any branch so the combinational block never infers a latch.
    pick = req;
    if (req == 2'b11) begin
      pick = (FIXED_PRIO != 0 || last_p1) ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/cache_arbiter.sv
// Shares one fully associative cache between instruction fetch (port 0) and
// data access (port 1). Define CACHE_ARB_TIMEOUT_EN to add a stuck-cache timeout.
module cache_arbiter
  import cache_arb_pkg::*;
#(
  parameter int A_W        = 8,
  parameter int D_W        = 8,
  parameter int CNT_W      = 8,
  parameter int FIXED_PRIO = 0,
  parameter int TIMEOUT    = 31
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             req0,
  input  logic             req1,
  input  logic             rw0,
  input  logic             rw1,
  input  logic [A_W-1:0]   addr0,
  input  logic [A_W-1:0]   addr1,
  input  logic [D_W-1:0]   wdata0,
  input  logic [D_W-1:0]   wdata1,
  output logic             ack0,
  output logic             ack1,
  output logic [D_W-1:0]   rdata,
  output logic [1:0]       grant,
  output logic             busy,
  output logic             c_enab,
  output logic             c_rw,
  output logic [A_W-1:0]   c_addr,
  output logic [D_W-1:0]   c_wdata,
  input  logic [3:0]       c_state,
  input  logic [D_W-1:0]   c_rdata,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt,
  output logic             err
);

  arb_state_t state;
  logic [1:0] pick;
  logic       accept;
  logic       waiting;
  logic       complete;
  logic       timed_out;
  logic       finishing;
  logic       miss_flag;

  cache_arb_rr #(.FIXED_PRIO(FIXED_PRIO)) u_rr (
    .clk     (clk),
    .clr     (clr),
    .req     ({req1, req0}),
    .advance (accept),
    .pick    (pick)
  );

  assign accept    = (state == ST_IDLE) && (pick != 2'b00);
  assign waiting   = (state == ST_ISSUE) || (state == ST_BUSY);
  assign complete  = (state == ST_BUSY) && (c_state == C_IDLE);
  assign finishing = complete || timed_out;

  // Drops as soon as the cache is back at idle, so it never sees enab in state 0 again.
  assign c_enab = (state == ST_ISSUE) || ((state == ST_BUSY) && (c_state != C_IDLE));

`ifdef CACHE_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_cnt;
  logic          err_q;

  assign timed_out = waiting && !complete && (tmo_cnt == TW'(TIMEOUT - 1));
  assign err       = err_q;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      tmo_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q   <= timed_out;
      tmo_cnt <= waiting ? tmo_cnt + TW'(1) : '0;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign timed_out      = 1'b0;
  assign err            = 1'b0;
`endif

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state     <= ST_IDLE;
      grant     <= 2'b00;
      busy      <= 1'b0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      rdata     <= '0;
      c_rw      <= 1'b0;
      c_addr    <= '0;
      c_wdata   <= '0;
      miss_flag <= 1'b0;
      hit_cnt   <= '0;
      miss_cnt  <= '0;
    end else begin
      // NOTE: registers update with non-blocking assignments so every branch sees pre-edge values.
      case (state)
        ST_IDLE: begin
          if (accept) begin
            grant     <= pick;
            busy      <= 1'b1;
            c_rw      <= pick[0] ? rw0    : rw1;
            c_addr    <= pick[0] ? addr0  : addr1;
            c_wdata   <= pick[0] ? wdata0 : wdata1;
            miss_flag <= 1'b0;
            state     <= ST_ISSUE;
          end
        end
        ST_ISSUE, ST_BUSY: begin
          if (state == ST_BUSY && c_state >= C_MISS_MIN) begin
            miss_flag <= 1'b1;
          end
          if (finishing) begin
            state <= ST_RESP;
            ack0  <= grant[0];
            ack1  <= grant[1];
            rdata <= c_rdata;
            if (complete) begin
              if (miss_flag) begin
                miss_cnt <= (&miss_cnt) ? miss_cnt : miss_cnt + CNT_W'(1);
              end else begin
                hit_cnt  <= (&hit_cnt) ? hit_cnt : hit_cnt + CNT_W'(1);
              end
            end
          end else if (state == ST_ISSUE && c_state != C_IDLE) begin
            state <= ST_BUSY;
          end
        end
        ST_RESP: begin
          ack0  <= 1'b0;
          ack1  <= 1'b0;
          grant <= 2'b00;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/cache_arbiter.md
Name: cache_arbiter

Overview:
- Shares the single fully associative LRU cache between two requesters of the accumulator processor: port 0 (instruction fetch) and port 1 (data load/store).
- Arbitrates, latches the winning request, and drives the cache's enab/rw/Addr/data_in.
- Tracks the cache's exported 4-bit state to detect completion, then returns read data with a one-cycle ack.
- Also keeps hit/miss statistics.

Parameters:
- A_W, 8, address width
- D_W, 8, data width
- CNT_W, 8, width of hit/miss statistic counters
- FIXED_PRIO, 0, 0 = round-robin; 1 = port 0 always wins
- TIMEOUT, 31, max cycles in ISSUE+BUSY (used only with the optional feature)

Ports:
- clk  in  1  system clock, all logic on posedge
- clr  in  1  asynchronous active-high reset
- req0/req1  in  1  request; held high until matching ack
- rw0/rw1  in  1  0 = read, 1 = write
- addr0/addr1  in  A_W  target address
- wdata0/wdata1  in  D_W  write data
- ack0/ack1  out  1  one-cycle completion pulse
- rdata  out  D_W  read data, valid while ack0|ack1
- grant  out  2  one-hot owner of current transaction
- busy  out  1  transaction in flight
- c_enab  out  1  cache enab
- c_rw  out  1  cache rw
- c_addr  out  A_W  cache Addr
- c_wdata  out  D_W  cache data_in
- c_state  in  4  cache state output
- c_rdata  in  D_W  cache data_out
- hit_cnt/miss_cnt  out  CNT_W  saturating statistics
- err  out  1  timeout pulse (tied 0 when the feature is absent)

Behaviour:
- Reset (async, clr=1): FSM=IDLE; all outputs 0; RR pointer favours port 0; counters 0. Reset mid-transaction drops it with no ack. c_enab=0 returns the cache to state 0 on its next edge. A still-high req is re-arbitrated after reset.
- FSM IDLE -> ISSUE -> BUSY -> RESP -> IDLE.
- IDLE: if any req, pick winner and latch rw/addr/wdata into c_rw/c_addr/c_wdata. Set grant, clear miss_flag, go ISSUE.
  - Round-robin: with both requesting, grant the port not granted last.
  - FIXED_PRIO=1: port 0 always wins.
- ISSUE: c_enab=1; go BUSY when c_state!=0.
- BUSY: set miss_flag if c_state>=2; go RESP when c_state==0.
- c_enab is combinational: c_enab = ISSUE | (BUSY & c_state!=0). It falls in the same cycle the cache returns to 0, so the cache never starts a second lookup.
- RESP: c_enab=0. Pulse ack of the granted port for exactly 1 cycle with rdata=c_rdata (registered). Increment miss_cnt if miss_flag, else hit_cnt; both saturate at all-ones. Return to IDLE; grant clears.
- New arbitration happens no earlier than the cycle after RESP (1 idle bubble minimum).
- Latency from accept edge to ack edge: hit = 3, read miss = 15, write miss = 13 cycles.
- Latched c_addr/c_wdata/c_rw stay stable ISSUE through RESP; requester inputs may change after accept.
- A req dropped before ack is illegal; an ack is still issued.
- Write transactions: rdata is don't-care but driven from c_rdata.

Optional Feature:
- CACHE_ARB_TIMEOUT_EN defined:
  - A cycle counter runs in ISSUE/BUSY.
  - On reaching TIMEOUT, go RESP with err=1 for that cycle, ack still pulsed, and no counter increment.
  - c_enab=0 in RESP resets the cache FSM.
- Undefined: no counter, err tied 0, ISSUE/BUSY wait indefinitely.

Decomposition:
- Package cache_arb_pkg holds:
  - FSM state encoding (IDLE, ISSUE, BUSY, RESP)
  - cache state constants C_IDLE=0 and C_MISS_MIN=2
  - latency constants LAT_HIT=3, LAT_RMISS=15, LAT_WMISS=13 for the bench
- One sub-module, cache_arb_rr: 2-way round-robin/fixed picker with the last-grant pointer.

Test Plan:
- Port 0 reads addr 0x00 after reset (cache zeroed, hit) -> ack0 at 3 cycles, rdata=0x00, hit_cnt=1.
- Port 1 writes 0x5A to 0x21 (miss) -> ack1 at 13 cycles, miss_cnt=1. Port 0 then reads 0x21 -> hit, rdata=0x5A, ack0 at 3 cycles.
- req0 and req1 both held high continuously -> grants alternate 0,1,0,1. With FIXED_PRIO=1, port 0 every time.
- Read miss to 0x40 -> exactly one ack at 15 cycles; c_enab falls the same cycle c_state returns to 0; no second lookup.
- clr asserted while c_state=7 -> all outputs 0 immediately, no ack; held req0 re-granted after release.
- CACHE_ARB_TIMEOUT_EN with c_state stuck at 5 -> err and ack pulse at TIMEOUT, counters unchanged.
